// File: rtl/video_pattern_gen.sv
// Raster timing generator with four selectable test patterns and registered video outputs.
// Defining PATGEN_NOISE_EN adds LFSR-driven salt-and-pepper noise on active pixels.
module video_pattern_gen #(
   parameter int   H_ACTIVE = 1280,
   parameter int   H_FP     = 110,
   parameter int   H_SYNC   = 40,
   parameter int   H_BP     = 220,
   parameter int   V_ACTIVE = 720,
   parameter int   V_FP     = 5,
   parameter int   V_SYNC   = 5,
   parameter int   V_BP     = 20,
   parameter logic HS_POL   = 1'b1,
   parameter logic VS_POL   = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] pattern_sel,
   output logic [7:0] tx_red,
   output logic [7:0] tx_green,
   output logic [7:0] tx_blue,
   output logic       tx_dv,
   output logic       tx_hs,
   output logic       tx_vs,
   output logic       frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_ZERO  = HW'(0);
   localparam logic [HW-1:0] H_ONE   = HW'(1);
   localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_C = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_ZERO  = VW'(0);
   localparam logic [VW-1:0] V_ONE   = VW'(1);
   localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_C = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [31:0]   BAR_W   = 32'(H_ACTIVE / 8);

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic [1:0]    pat_q, pat_d;
   logic          dv_q, hs_q, vs_q, fs_q;
   logic [23:0]   rgb_q;

   logic          at_origin_s, active_s, hs_on_s, vs_on_s;
   logic [1:0]    pat_s;
   logic [31:0]   x_s;
   logic [7:0]    x8_s, y8_s;
   logic [2:0]    bar_s;
   logic [23:0]   pat_rgb_s, pix_s;

   assign at_origin_s = (h_q == H_ZERO) && (v_q == V_ZERO);
   assign active_s    = (h_q < H_ACT_C) && (v_q < V_ACT_C);
   assign hs_on_s     = (h_q >= HS_BEG) && (h_q < HS_END);
   assign vs_on_s     = (v_q >= VS_BEG) && (v_q < VS_END);
   assign x_s         = 32'(h_q);
   assign x8_s        = 8'(h_q);
   assign y8_s        = 8'(v_q);

   // The first pixel of a frame already uses the freshly sampled selection.
   assign pat_s = at_origin_s ? pattern_sel : pat_q;

   // Raster counter next state; dropping en abandons the frame.
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (!en) begin
         h_d = H_ZERO;
         v_d = V_ZERO;
      end else if (h_q == H_LAST) begin
         h_d = H_ZERO;
         if (v_q == V_LAST) begin
            v_d = V_ZERO;
         end else begin
            v_d = v_q + V_ONE;
         end
      end else begin
         h_d = h_q + H_ONE;
         v_d = v_q;
      end
   end

   // Pattern selection is latched once per frame.
   always_comb begin
      if (en && at_origin_s) begin
         pat_d = pattern_sel;
      end else begin
         pat_d = pat_q;
      end
   end

   // Bar index by threshold comparison avoids a divider for non power-of-two widths.
   always_comb begin
      bar_s = 3'd0;
      for (int k = 1; k < 8; k++) begin
         bar_s = (x_s >= 32'(k) * BAR_W) ? 3'(k) : bar_s;
      end
   end

   // Bar colour components: red off for bars 2,3,6,7; green off for 4..7; blue off for odd bars.
   always_comb begin
      case (pat_s)
         2'd0:    pat_rgb_s = {{8{~bar_s[1]}}, {8{~bar_s[2]}}, {8{~bar_s[0]}}};
         2'd1:    pat_rgb_s = {x8_s, y8_s, 8'h00};
         2'd2:    pat_rgb_s = (x8_s[4] ^ y8_s[4]) ? 24'hFFFFFF : 24'h000000;
         2'd3:    pat_rgb_s = 24'h808080;
         default: pat_rgb_s = 24'h000000;
      endcase
   end

`ifdef PATGEN_NOISE_EN
   logic [15:0] lfsr_q, lfsr_d;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // The LFSR only steps on pixels that are actually displayed.
   always_comb begin
      if (en && active_s) begin
         lfsr_d = lfsr_next(lfsr_q);
      end else begin
         lfsr_d = lfsr_q;
      end
   end

   always_comb begin
      if (lfsr_q[15:10] == 6'd0) begin
         pix_s = lfsr_q[0] ? 24'hFFFFFF : 24'h000000;
      end else begin
         pix_s = pat_rgb_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   always_comb begin
      pix_s = pat_rgb_s;
   end
`endif

   // Raster position and frame pattern state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q   <= H_ZERO;
         v_q   <= V_ZERO;
         pat_q <= 2'd0;
      end else begin
         h_q   <= h_d;
         v_q   <= v_d;
         pat_q <= pat_d;
      end
   end

   // Output stage: one clock behind the raster counters, idle while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dv_q  <= 1'b0;
         hs_q  <= ~HS_POL;
         vs_q  <= ~VS_POL;
         fs_q  <= 1'b0;
         rgb_q <= 24'h000000;
      end else if (en) begin
         dv_q  <= active_s;
         hs_q  <= hs_on_s ? HS_POL : ~HS_POL;
         vs_q  <= vs_on_s ? VS_POL : ~VS_POL;
         fs_q  <= at_origin_s;
         rgb_q <= active_s ? pix_s : 24'h000000;
      end else begin
         dv_q  <= 1'b0;
         hs_q  <= ~HS_POL;
         vs_q  <= ~VS_POL;
         fs_q  <= 1'b0;
         rgb_q <= 24'h000000;
      end
   end

   assign tx_red      = rgb_q[23:16];
   assign tx_green    = rgb_q[15:8];
   assign tx_blue     = rgb_q[7:0];
   assign tx_dv       = dv_q;
   assign tx_hs       = hs_q;
   assign tx_vs       = vs_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen on a 14x7 raster: frame-position reference model plus directed checks.
module tb_video_pattern_gen;

   localparam int H_ACT  = 8;
   localparam int H_FPW  = 2;
   localparam int H_SYW  = 2;
   localparam int H_BPW  = 2;
   localparam int V_ACT  = 4;
   localparam int V_FPW  = 1;
   localparam int V_SYW  = 1;
   localparam int V_BPW  = 1;
   localparam int H_TOT  = H_ACT + H_FPW + H_SYW + H_BPW;
   localparam int V_TOT  = V_ACT + V_FPW + V_SYW + V_BPW;
   localparam int FRAME  = H_TOT * V_TOT;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [1:0] pattern_sel = 2'd0;
   logic [7:0] tx_red, tx_green, tx_blue;
   logic       tx_dv, tx_hs, tx_vs, frame_start;
   logic [23:0] rgb;

   int checks = 0;
   int failures = 0;

   // reference model state
   int          m_pos = 0;
   logic [1:0]  m_pat = 2'd0;
   logic        exp_dv = 1'b0, exp_hs = 1'b0, exp_vs = 1'b0, exp_fs = 1'b0;
   logic [23:0] exp_rgb = 24'h000000;
`ifdef PATGEN_NOISE_EN
   logic [15:0] m_lfsr = 16'hACE1;
   int          m_hits = 0;
`endif

   // per-frame statistics gathered by frame_stats
   int st_wait, st_dv, st_hs, st_vs, st_fs, st_grey, st_other;
   logic [23:0] st_row [8];
   logic [23:0] bar_ref [8];

   assign rgb = {tx_red, tx_green, tx_blue};

   video_pattern_gen #(
      .H_ACTIVE(H_ACT), .H_FP(H_FPW), .H_SYNC(H_SYW), .H_BP(H_BPW),
      .V_ACTIVE(V_ACT), .V_FP(V_FPW), .V_SYNC(V_SYW), .V_BP(V_BPW),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
      .tx_red(tx_red), .tx_green(tx_green), .tx_blue(tx_blue),
      .tx_dv(tx_dv), .tx_hs(tx_hs), .tx_vs(tx_vs), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, expv, $time);
      end
   endtask

   function automatic logic m_active(input int p);
      return ((p % H_TOT) < H_ACT) && ((p / H_TOT) < V_ACT);
   endfunction

   function automatic logic m_hsync(input int p);
      int x = p % H_TOT;
      return (x >= H_ACT + H_FPW) && (x < H_ACT + H_FPW + H_SYW);
   endfunction

   function automatic logic m_vsync(input int p);
      int y = p / H_TOT;
      return (y >= V_ACT + V_FPW) && (y < V_ACT + V_FPW + V_SYW);
   endfunction

   function automatic logic [23:0] m_bar(input int b);
      case (b)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   function automatic logic [23:0] m_pattern(input int p, input logic [1:0] pat);
      int x = p % H_TOT;
      int y = p / H_TOT;
      if (!m_active(p)) return 24'h000000;
      case (pat)
         2'd0: return m_bar(x / (H_ACT / 8));
         2'd1: return {8'(x), 8'(y), 8'h00};
         2'd2: return (((x / 16) + (y / 16)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
         default: return 24'h808080;
      endcase
   endfunction

`ifdef PATGEN_NOISE_EN
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      int v = int'(s);
      int fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
      return 16'(((v << 1) | fb) & 16'hFFFF);
   endfunction
`endif

   task automatic set_idle();
      exp_dv = 1'b0; exp_hs = 1'b0; exp_vs = 1'b0; exp_fs = 1'b0; exp_rgb = 24'h000000;
   endtask

   // Reference model: a single frame-position counter driven by the sampled inputs.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_pos = 0;
            m_pat = 2'd0;
            set_idle();
`ifdef PATGEN_NOISE_EN
            m_lfsr = 16'hACE1;
`endif
         end else if (!en) begin
            m_pos = 0;
            set_idle();
         end else begin
            if (m_pos == 0) m_pat = pattern_sel;
            exp_dv  = m_active(m_pos);
            exp_hs  = m_hsync(m_pos);
            exp_vs  = m_vsync(m_pos);
            exp_fs  = (m_pos == 0);
            exp_rgb = m_pattern(m_pos, m_pat);
`ifdef PATGEN_NOISE_EN
            if (exp_dv) begin
               if ((m_lfsr >> 10) == 16'd0) begin
                  exp_rgb = m_lfsr[0] ? 24'hFFFFFF : 24'h000000;
                  m_hits++;
               end
               m_lfsr = lfsr_step(m_lfsr);
            end
`endif
            m_pos = (m_pos + 1) % FRAME;
         end
      end
   end

   // Cycle compare against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         chk("dv", 32'(tx_dv), 32'(exp_dv));
         chk("hs", 32'(tx_hs), 32'(exp_hs));
         chk("vs", 32'(tx_vs), 32'(exp_vs));
         chk("fs", 32'(frame_start), 32'(exp_fs));
         chk("rgb", 32'(rgb), 32'(exp_rgb));
      end
   end

   task automatic frame_stats();
      int g = 0;
      st_dv = 0; st_hs = 0; st_vs = 0; st_fs = 0; st_grey = 0; st_other = 0;
      while (!frame_start && g < 300) begin
         @(negedge clk);
         g++;
      end
      st_wait = g;
      if (!frame_start) begin
         failures++;
         $display("FAIL fs_timeout actual=none expected=frame_start within 300 cycles");
      end
      for (int i = 0; i < FRAME; i++) begin
         if (i > 0) @(negedge clk);
         st_dv += int'(tx_dv);
         st_hs += int'(tx_hs);
         st_vs += int'(tx_vs);
         st_fs += int'(frame_start);
         if (tx_dv && rgb == 24'h808080) st_grey++;
         if (tx_dv && rgb != 24'h808080) st_other++;
         if (i < 8) st_row[i] = rgb;
      end
   endtask

   initial begin
      int idle_bad;
      int grey_part;
      int g;
      bar_ref = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

      // reset state
      repeat (2) @(posedge clk);
      #2;
      chk("rst_dv", 32'(tx_dv), 32'd0);
      chk("rst_hs", 32'(tx_hs), 32'd0);
      chk("rst_vs", 32'(tx_vs), 32'd0);
      chk("rst_rgb", 32'(rgb), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      en = 1'b1;

      // three frames of colour bars
      frame_stats();
      chk("f1_dv", 32'(st_dv), 32'd32);
      chk("f1_hs", 32'(st_hs), 32'd14);
      chk("f1_vs", 32'(st_vs), 32'd14);
      chk("f1_fs", 32'(st_fs), 32'd1);
`ifndef PATGEN_NOISE_EN
      for (int i = 0; i < 8; i++) chk("bar_row", 32'(st_row[i]), 32'(bar_ref[i]));
`endif
      for (int f = 0; f < 2; f++) begin
         frame_stats();
         chk("fs_period", 32'(st_wait), 32'd1);
         chk("fn_dv", 32'(st_dv), 32'd32);
         chk("fn_fs", 32'(st_fs), 32'd1);
      end

      // switch pattern at pixel (3,1)
      repeat (17) @(posedge clk);
      #2;
      pattern_sel = 2'd3;
      grey_part = 0;
      g = 0;
      @(negedge clk);
      while (!frame_start && g < 200) begin
         if (tx_dv && rgb == 24'h808080) grey_part++;
         @(negedge clk);
         g++;
      end
      chk("switch_fs_seen", 32'(frame_start), 32'd1);
`ifndef PATGEN_NOISE_EN
      chk("switch_rest_bars", 32'(grey_part), 32'd0);
`endif
      frame_stats();
      chk("switch_wait", 32'(st_wait), 32'd0);
`ifndef PATGEN_NOISE_EN
      chk("switch_grey", 32'(st_grey), 32'd32);
`endif

      // drop en at (5,2), hold low 10 clk
      repeat (33) @(posedge clk);
      #2;
      chk("pre_drop_dv", 32'(tx_dv), 32'd1);
      en = 1'b0;
      idle_bad = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (tx_dv || tx_hs || tx_vs || frame_start || rgb != 24'h000000) idle_bad++;
      end
      chk("en_low_idle", 32'(idle_bad), 32'd0);
      #1;
      en = 1'b1;
      @(posedge clk);
      #1;
      chk("en_rise_fs", 32'(frame_start), 32'd1);
      chk("en_rise_dv", 32'(tx_dv), 32'd1);
`ifndef PATGEN_NOISE_EN
      chk("en_rise_rgb", 32'(rgb), 32'h808080);
`endif

      // async reset mid-line
      repeat (2) @(posedge clk);
      #2;
      chk("pre_rst_dv", 32'(tx_dv), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_dv", 32'(tx_dv), 32'd0);
      chk("async_rgb", 32'(rgb), 32'd0);
      chk("async_fs", 32'(frame_start), 32'd0);
      pattern_sel = 2'd1;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;

      // gradient frame then checkerboard frame
      frame_stats();
      chk("grad_wait", 32'(st_wait), 32'd2);
      chk("grad_dv", 32'(st_dv), 32'd32);
`ifndef PATGEN_NOISE_EN
      chk("grad_px5", 32'(st_row[5]), 32'h050000);
      chk("grad_px7", 32'(st_row[7]), 32'h070000);
`endif
      pattern_sel = 2'd2;
      frame_stats();
      chk("chk_dv", 32'(st_dv), 32'd32);

`ifdef PATGEN_NOISE_EN
      begin
         int hits0;
         int seen;
         pattern_sel = 2'd3;
         frame_stats();
         hits0 = m_hits;
         seen = 0;
         for (int f = 0; f < 64; f++) begin
            frame_stats();
            seen += st_other;
         end
         chk("noise_count", 32'(seen), 32'(m_hits - hits0));
      end
`endif

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with parameters: H_ACTIVE 1280 (active pixels per line, multiple of 8); H_FP 110, H_SYNC 40, H_BP 220 (horizontal porch and sync widths in clocks); V_ACTIVE 720; V_FP 5, V_SYNC 5, V_BP 20 (vertical porch and sync widths in lines); HS_POL 1, VS_POL 1 (sync active level).
REQ-002 Ports SHALL be:
- clk  in  1  pixel clock.
- rst_n  in  1  async active-low reset.
- en  in  1  run enable.
- pattern_sel  in  2  pattern select.
- tx_red, tx_green, tx_blue  out  8 each  pixel data.
- tx_dv  out  1  active video.
- tx_hs  out  1  hsync.
- tx_vs  out  1  vsync.
- frame_start  out  1  one-cycle pulse with first pixel of frame.

Function
REQ-003 Counters SHALL be h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise.
- h_cnt increments each clk while en=1.
- At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
- At V_TOTAL-1, v_cnt wraps to 0.
REQ-004 Line and frame order SHALL be active, front porch, sync, back porch.
REQ-005 tx_dv SHALL be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-006 tx_hs SHALL equal HS_POL iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
REQ-007 tx_vs SHALL equal VS_POL for whole lines with V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL.
REQ-008 All outputs SHALL be registered, with exactly 1 clk latency from counter state to output.
REQ-009 frame_start SHALL be 1 for the single cycle in which tx_dv reflects h_cnt=0, v_cnt=0.
REQ-010 pattern_sel SHALL be sampled only when h_cnt=0 and v_cnt=0; mid-frame changes take effect from the next frame.
REQ-011 Patterns SHALL be (x=h_cnt, y=v_cnt, active region only):
- 0: colour bars, bar=x/(H_ACTIVE/8), in order white, yellow, cyan, green, magenta, red, blue, black (full-scale 0xFF/0x00 components).
- 1: gradient, red=x[7:0], green=y[7:0], blue=0x00.
- 2: checkerboard, 0xFFFFFF if x[4]^y[4], else 0x000000.
- 3: flat grey, 0x808080.
REQ-012 RGB outputs SHALL be 0x00 whenever tx_dv=0.
REQ-013 While en=0, counters SHALL hold at 0, tx_dv=0, syncs SHALL be inactive, and RGB SHALL be 0.
REQ-014 When en rises, the first registered output SHALL be pixel (0,0) with frame_start=1.
REQ-015 If en falls mid-frame, counters SHALL clear to 0 on the next clk; no partial-frame resumption.

Reset
REQ-016 On rst_n=0 the block SHALL asynchronously set:
- h_cnt, v_cnt to 0;
- latched pattern to 0;
- tx_dv, frame_start to 0;
- tx_hs to ~HS_POL, tx_vs to ~VS_POL;
- RGB to 0.
REQ-017 Reset deassertion mid-frame SHALL restart at pixel (0,0) on the first enabled clk.

Configuration
REQ-018 With macro PATGEN_NOISE_EN defined, the block SHALL inject salt-and-pepper noise:
- 16-bit Fibonacci LFSR, taps 16,14,13,11, seeded 16'hACE1 by reset.
- The LFSR advances once per active pixel only.
- When lfsr[15:10]==0, the pixel is replaced by 0xFFFFFF if lfsr[0]=1, else 0x000000.
REQ-019 Without PATGEN_NOISE_EN, no LFSR SHALL be present and pixels SHALL match REQ-011 exactly.

Verification
Small timing for all scenarios: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1 (H_TOTAL 14, V_TOTAL 7, 98 clk/frame).
REQ-020 Timing: en=1 for 3 frames -> frame_start every 98 clk, 32 tx_dv cycles/frame, tx_hs high on cycles 10-11 of each line, tx_vs high for line 5 (14 clk).
REQ-021 Colour bars: pattern_sel=0 -> active line pixels 0..7 = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; blanking RGB=0.
REQ-022 Pattern switch: change pattern_sel 0->3 at pixel (3,1) -> rest of frame stays bars; next frame all active pixels 808080.
REQ-023 Enable/reset: drop en at (5,2), raise after 10 clk -> outputs idle while low, then frame_start=1 with pixel (0,0) one clk after en rises. Pulse rst_n low mid-line -> outputs at reset values immediately, without waiting for a clk edge.
REQ-024 Noise (PATGEN_NOISE_EN): pattern_sel=3, run 64 frames -> replaced-pixel count matches a reference LFSR model exactly (about 1/64 of 2048 active pixels); LFSR state unchanged across blanking.
